mc_ctrl_fsm: RTL and testbench

Multicycle MIPS control unit, next generation: holds its own state register, with no external state/next-state loop. Decodes the opcode and drives all datapath enables and mux selects for one instruction at a time. Adds bne, I-type ALU ops, memory-ready wait handshake, a wait timeout and an illegal-opcode trap. Sits between the instruction register opcode field and the multicycle datapath/memory port.

---
 rtl/mc_ctrl_fsm.sv | 191 +++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM with memory-ready waits, wait timeout and an illegal-opcode trap.
// Optional I-type ALU support (addi/andi/ori/slti) is enabled by defining MC_CTRL_IMM_ALU_EN.
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 0,
    parameter int TO_W        = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_wr,
    output logic       pc_wr_cond,
    output logic       br_ne,
    output logic       i_or_d,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic       reg_wr,
    output logic       reg_dst,
    output logic       ext_zero,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic [3:0] state,
    output logic       trap
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RTWB   = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_BNE    = 4'd10;
    localparam logic [3:0] S_IEXEC  = 4'd11;
    localparam logic [3:0] S_IWB    = 4'd12;
    localparam logic [3:0] S_TRAP   = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [3:0]      state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            stall;

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE; else stall = 1'b1;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BEQ;
                    OP_BNE:        state_d = S_BNE;
                    OP_J:          state_d = S_JUMP;
`ifdef MC_CTRL_IMM_ALU_EN
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
`endif
                    default:       state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB; else stall = 1'b1;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH; else stall = 1'b1;
            S_EXEC:   state_d = S_RTWB;
            S_RTWB:   state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_BNE:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef MC_CTRL_IMM_ALU_EN
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
`endif
            default:  state_d = S_TRAP;
        endcase
        // The last allowed stall cycle traps unless mem_ready arrives in it (then stall is 0).
        if (MEM_TIMEOUT > 0 && stall && cnt_q == CNT_LAST) state_d = S_TRAP;
    end

    // Counter only advances while stalling, so any entry into a wait state starts from 0.
    assign cnt_d = stall ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        pc_wr      = 1'b0;
        pc_wr_cond = 1'b0;
        br_ne      = 1'b0;
        i_or_d     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        ext_zero   = 1'b0;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        alu_src_b  = 2'b00;
        trap       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                ir_wr     = mem_ready;
                pc_wr     = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_rd = 1'b1;
                i_or_d = 1'b1;
            end
            S_MEMWB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_wr = 1'b1;
                i_or_d = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RTWB: begin
                reg_wr  = 1'b1;
                reg_dst = 1'b1;
            end
            S_BEQ, S_BNE: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_wr_cond = 1'b1;
                pc_src     = 2'b01;
                br_ne      = (state_q == S_BNE);
            end
            S_JUMP: begin
                pc_wr  = 1'b1;
                pc_src = 2'b10;
            end
`ifdef MC_CTRL_IMM_ALU_EN
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                ext_zero  = (op == OP_ANDI) || (op == OP_ORI);
            end
            S_IWB: begin
                reg_wr   = 1'b1;
                ext_zero = (op == OP_ANDI) || (op == OP_ORI);
            end
`endif
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: vector table of per-cycle inputs and expected state, a spec-derived
// control table per state, and an expectation queue popped when outputs are sampled.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       pc_wr, pc_wr_cond, br_ne, i_or_d, mem_rd, mem_wr, ir_wr;
        logic       mem_to_reg, alu_src_a, reg_wr, reg_dst, ext_zero, trap;
        logic [1:0] pc_src, alu_op, alu_src_b;
    } ctl_t;

    typedef struct packed {
        logic       rst_n;
        logic [5:0] op;
        logic       mr;
        logic [3:0] st;
    } vec_t;

    typedef struct packed {
        logic [3:0] st;
        ctl_t       ctl;
    } exp_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_ORI = 6'b001101, OP_BAD = 6'b111111;

    logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
    logic [5:0] op = '0;
    logic pc_wr, pc_wr_cond, br_ne, i_or_d, mem_rd, mem_wr, ir_wr;
    logic mem_to_reg, alu_src_a, reg_wr, reg_dst, ext_zero, trap;
    logic [1:0] pc_src, alu_op, alu_src_b;
    logic [3:0] state;

    int n_cmp = 0, n_err = 0;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_wr(pc_wr), .pc_wr_cond(pc_wr_cond), .br_ne(br_ne), .i_or_d(i_or_d),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_wr(ir_wr), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .reg_wr(reg_wr), .reg_dst(reg_dst), .ext_zero(ext_zero),
        .pc_src(pc_src), .alu_op(alu_op), .alu_src_b(alu_src_b), .state(state), .trap(trap)
    );

    // Control outputs each state must show, straight from the state/output table.
    function automatic ctl_t ref_ctl(input logic [3:0] st, input logic [5:0] o, input logic mr);
        ctl_t c = '0;
        case (st)
            4'd0:  begin c.mem_rd = 1; c.alu_src_b = 2'b01; c.ir_wr = mr; c.pc_wr = mr; end
            4'd1:  c.alu_src_b = 2'b11;
            4'd2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4'd3:  begin c.mem_rd = 1; c.i_or_d = 1; end
            4'd4:  begin c.reg_wr = 1; c.mem_to_reg = 1; end
            4'd5:  begin c.mem_wr = 1; c.i_or_d = 1; end
            4'd6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            4'd7:  begin c.reg_wr = 1; c.reg_dst = 1; end
            4'd8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_wr_cond = 1; c.pc_src = 2'b01; end
            4'd10: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_wr_cond = 1; c.pc_src = 2'b01; c.br_ne = 1; end
            4'd9:  begin c.pc_wr = 1; c.pc_src = 2'b10; end
            4'd11: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b11;
                         c.ext_zero = (o == 6'b001100 || o == 6'b001101); end
            4'd12: begin c.reg_wr = 1; c.ext_zero = (o == 6'b001100 || o == 6'b001101); end
            4'd13: c.trap = 1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic add(input logic r, input logic [5:0] o, input logic m, input logic [3:0] s);
        vec_t v;
        v.rst_n = r; v.op = o; v.mr = m; v.st = s;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, queue its expectation, then compare mid-cycle.
    task automatic apply(input vec_t v, input string tag);
        exp_t e, got;
        @(posedge clk);
        #1;
        rst_n = v.rst_n; op = v.op; mem_ready = v.mr;
        e.st = v.st; e.ctl = ref_ctl(v.st, v.op, v.mr);
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        got.st = state;
        got.ctl = '{pc_wr, pc_wr_cond, br_ne, i_or_d, mem_rd, mem_wr, ir_wr, mem_to_reg,
                    alu_src_a, reg_wr, reg_dst, ext_zero, trap, pc_src, alu_op, alu_src_b};
        n_cmp++;
        if (got.st !== e.st) begin
            n_err++;
            $display("FAIL %s state: got %0d expected %0d", tag, got.st, e.st);
        end
        n_cmp++;
        if (got.ctl !== e.ctl) begin
            n_err++;
            $display("FAIL %s ctl (state %0d): got %h expected %h", tag, e.st, got.ctl, e.ctl);
        end
    endtask

    initial begin
        // reset with mem_ready high: FETCH decode with ir_wr/pc_wr following mem_ready
        add(0, OP_LW, 1, 0);
        // lw, no wait: 0 1 2 3 4
        add(1, OP_LW, 1, 0); add(1, OP_LW, 1, 1); add(1, OP_LW, 1, 2); add(1, OP_LW, 1, 3); add(1, OP_LW, 1, 4);
        // sw: 0 1 2 5
        add(1, OP_SW, 1, 0); add(1, OP_SW, 1, 1); add(1, OP_SW, 1, 2); add(1, OP_SW, 1, 5);
        // beq / bne / j / R-type
        add(1, OP_BEQ, 1, 0); add(1, OP_BEQ, 1, 1); add(1, OP_BEQ, 1, 8);
        add(1, OP_BNE, 1, 0); add(1, OP_BNE, 1, 1); add(1, OP_BNE, 1, 10);
        add(1, OP_J, 1, 0); add(1, OP_J, 1, 1); add(1, OP_J, 1, 9);
        add(1, OP_R, 1, 0); add(1, OP_R, 1, 1); add(1, OP_R, 1, 6); add(1, OP_R, 1, 7);
        // two FETCH stall cycles, then one fetch cycle
        add(1, OP_J, 0, 0); add(1, OP_J, 0, 0); add(1, OP_J, 1, 0); add(1, OP_J, 1, 1); add(1, OP_J, 1, 9);
        // lw with one MEMRD stall (mem_ready ignored in MEMADR)
        add(1, OP_LW, 1, 0); add(1, OP_LW, 1, 1); add(1, OP_LW, 0, 2); add(1, OP_LW, 0, 3);
        add(1, OP_LW, 1, 3); add(1, OP_LW, 0, 4);
        // sw: mem_ready arrives on 4th MEMWR stall cycle -> no trap
        add(1, OP_SW, 1, 0); add(1, OP_SW, 1, 1); add(1, OP_SW, 1, 2); add(1, OP_SW, 0, 5);
        add(1, OP_SW, 0, 5); add(1, OP_SW, 0, 5); add(1, OP_SW, 1, 5);
        // FETCH stall counter starts from 0 again: 3 stalls then fetch, no trap
        add(1, OP_R, 0, 0); add(1, OP_R, 0, 0); add(1, OP_R, 0, 0); add(1, OP_R, 1, 0); add(1, OP_R, 1, 1);
        add(1, OP_R, 1, 6); add(1, OP_R, 1, 7);
        // immediate ops
`ifdef MC_CTRL_IMM_ALU_EN
        add(1, OP_ORI, 1, 0); add(1, OP_ORI, 1, 1); add(1, OP_ORI, 1, 11); add(1, OP_ORI, 1, 12);
        add(1, OP_ADDI, 1, 0); add(1, OP_ADDI, 1, 1); add(1, OP_ADDI, 1, 11); add(1, OP_ADDI, 1, 12);
`else
        add(1, OP_ORI, 1, 0); add(1, OP_ORI, 1, 1); add(1, OP_ORI, 1, 13); add(1, OP_ORI, 0, 13);
        add(0, OP_ADDI, 1, 0);
        add(1, OP_ADDI, 1, 0); add(1, OP_ADDI, 1, 1); add(1, OP_ADDI, 1, 13);
`endif
        add(0, OP_SW, 0, 0);
        // sw timeout: 4 stalls in MEMWR -> TRAP, mem_ready then ignored
        add(1, OP_SW, 1, 0); add(1, OP_SW, 1, 1); add(1, OP_SW, 1, 2); add(1, OP_SW, 0, 5);
        add(1, OP_SW, 0, 5); add(1, OP_SW, 0, 5); add(1, OP_SW, 0, 5); add(1, OP_SW, 1, 13);
        add(1, OP_SW, 1, 13);
        // async reset out of TRAP
        add(0, OP_SW, 1, 0);
        // illegal opcode
        add(1, OP_BAD, 1, 0); add(1, OP_BAD, 1, 1); add(1, OP_BAD, 1, 13);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // TRAP must hold for 100 cycles whatever mem_ready does
        for (int i = 0; i < 100; i++) begin
            vec_t v;
            v.rst_n = 1; v.op = OP_BAD; v.mr = 1'($urandom_range(0, 1)); v.st = 4'd13;
            apply(v, $sformatf("trap_hold%0d", i));
        end

        // Reset dropped mid-cycle must clear state and trap immediately
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (state !== 4'd0 || trap !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got state %0d trap %0b expected state 0 trap 0", state, trap);
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
